fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: owns the PC, issues word fetches to a one-cycle
// instruction memory, buffers returned words in a 2-entry FIFO and hands
// {inst, pc} to decode over a valid/ready handshake. Redirects from execute
// flush the FIFO and discard the wrong-path response.
module fetch_stage #(
    parameter int unsigned    XLEN     = 64,
    parameter int unsigned    ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            fetch_fault
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            fault_q, fault_d;

    logic [ILEN-1:0] fifo_inst_q [2];
    logic [ILEN-1:0] fifo_inst_d [2];
    logic [XLEN-1:0] fifo_pc_q [2];
    logic [XLEN-1:0] fifo_pc_d [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            pop;
    logic            push;
    logic            wr_ptr;
    logic [2:0]      credits;

    // Handshake, credit check and request generation. With a one-cycle memory
    // the only outstanding response always returns in the redirect cycle itself,
    // so redirect discards it directly (it blocks the push) rather than through
    // a kill flag carried into a later cycle. Gating with rst_n keeps imem_req
    // low for the whole reset interval.
    always_comb begin
        pop       = (count_q != 2'd0) && id_ready;
        push      = inflight_q && !redirect;
        wr_ptr    = rd_ptr_q ^ count_q[0];
        credits   = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
        imem_req  = rst_n && !fault_q && !redirect && (credits < 3'd2);
        imem_addr = pc_q;
    end

    // Decode-side outputs come straight from the FIFO head.
    always_comb begin
        id_valid    = (count_q != 2'd0);
        id_inst     = id_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
        id_pc       = id_valid ? fifo_pc_q[rd_ptr_q] : '0;
        fetch_fault = fault_q;
    end

    // Next-state: redirect takes priority over push, pop and issue.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = imem_req;
        fault_d     = fault_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            fault_d = (redirect_pc[1:0] != 2'b00);
            count_d = 2'd0;
        end else begin
            if (push) begin
                fifo_inst_d[wr_ptr] = imem_rdata;
                fifo_pc_d[wr_ptr]   = req_pc_q;
            end
            rd_ptr_d = rd_ptr_q ^ pop;
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            if (imem_req) begin
                pc_d     = pc_q + XLEN'(4);
                req_pc_d = pc_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_inst_q[i] <= NOP_INST;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            fault_q     <= fault_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: streaming, stall, redirect, misaligned
// redirect fault, PC wrap and asynchronous reset mid-stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Address-derived instruction word so every fetch is distinguishable.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hCAFE_0000;
    endfunction

    // One-cycle instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= inst_of(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc);
        chk({tag, " valid"}, 64'(id_valid), 64'd1);
        chk({tag, " pc"}, id_pc, pc);
        chk({tag, " inst"}, 64'(id_inst), 64'(inst_of(pc)));
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        #1;
        chk("rst req", 64'(imem_req), 64'd0);
        chk("rst addr", imem_addr, 64'h0);
        chk("rst valid", 64'(id_valid), 64'd0);
        chk("rst inst", 64'(id_inst), 64'(NOP));
        chk("rst pc", id_pc, 64'h0);
        chk("rst fault", 64'(fetch_fault), 64'd0);

        // Streaming from reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s0 req", 64'(imem_req), 64'd1);
        chk("s0 addr", imem_addr, 64'h0);
        @(negedge clk); #1;
        chk("s1 valid", 64'(id_valid), 64'd0);
        chk("s1 addr", imem_addr, 64'h4);
        @(negedge clk); #1;
        chk_head("s2", 64'h0);
        chk("s2 addr", imem_addr, 64'h8);
        @(negedge clk); #1;
        chk_head("s3", 64'h4);
        @(negedge clk); #1;
        chk_head("s4", 64'h8);

        // Stall: FIFO fills with 8,12, requests stop, head holds
        id_ready = 1'b0;
        #1;
        chk("stall req0", 64'(imem_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk_head("stall", 64'h8);
            chk("stall req", 64'(imem_req), 64'd0);
        end
        id_ready = 1'b1;
        #1;
        chk("resume req", 64'(imem_req), 64'd1);
        chk("resume addr", imem_addr, 64'h10);
        @(negedge clk); #1;
        chk_head("resume1", 64'hC);
        chk("resume1 addr", imem_addr, 64'h14);
        @(negedge clk); #1;
        chk_head("resume2", 64'h10);

        // Redirect while 0x14 response is in flight
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        #1;
        chk("redir req", 64'(imem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("redir valid", 64'(id_valid), 64'd0);
        chk("redir req1", 64'(imem_req), 64'd1);
        chk("redir addr", imem_addr, 64'h100);
        @(negedge clk); #1;
        chk("redir valid1", 64'(id_valid), 64'd0);
        chk("redir addr1", imem_addr, 64'h104);
        @(negedge clk); #1;
        chk_head("redir head", 64'h100);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("mis fault", 64'(fetch_fault), 64'd1);
        chk("mis req", 64'(imem_req), 64'd0);
        chk("mis valid", 64'(id_valid), 64'd0);
        chk("mis addr", imem_addr, 64'h102);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("mis hold req", 64'(imem_req), 64'd0);
            chk("mis hold fault", 64'(fetch_fault), 64'd1);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        #1;
        chk("fix req0", 64'(imem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("fix fault", 64'(fetch_fault), 64'd0);
        chk("fix req", 64'(imem_req), 64'd1);
        chk("fix addr", imem_addr, 64'h200);
        @(negedge clk); #1;
        chk("fix addr1", imem_addr, 64'h204);
        @(negedge clk); #1;
        chk_head("fix head", 64'h200);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("wrap addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap addr1", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap addr2", imem_addr, 64'h0);
        chk_head("wrap h0", 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap addr3", imem_addr, 64'h4);
        chk_head("wrap h1", 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); #1;
        chk_head("wrap h2", 64'h0);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(id_valid), 64'd0);
        chk("arst inst", 64'(id_inst), 64'(NOP));
        chk("arst req", 64'(imem_req), 64'd0);
        chk("arst pc", id_pc, 64'h0);
        chk("arst addr", imem_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst rel req", 64'(imem_req), 64'd1);
        chk("arst rel addr", imem_addr, 64'h0);
        @(negedge clk); #1;
        chk("arst rel valid", 64'(id_valid), 64'd0);
        chk("arst rel addr1", imem_addr, 64'h4);
        @(negedge clk); #1;
        chk_head("arst head", 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
